// File: rtl/lcd_timing_gen_if.sv
// Pixel-side bundle between the LCD timing generator, the renderer and the panel pins.
// The master side is the timing generator; the slave side is the renderer/panel.
interface lcd_timing_gen_if;
  logic [4:0] i_R;
  logic [5:0] i_G;
  logic [4:0] i_B;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_frame_start;
  logic       o_lcd_hs;
  logic       o_lcd_vs;
  logic       o_lcd_de;
  logic [4:0] o_lcd_R;
  logic [5:0] o_lcd_G;
  logic [4:0] o_lcd_B;

  modport master (
    input  i_R, i_G, i_B,
    output o_x, o_y, o_frame_start,
    output o_lcd_hs, o_lcd_vs, o_lcd_de,
    output o_lcd_R, o_lcd_G, o_lcd_B
  );

  modport slave (
    output i_R, i_G, i_B,
    input  o_x, o_y, o_frame_start,
    input  o_lcd_hs, o_lcd_vs, o_lcd_de,
    input  o_lcd_R, o_lcd_G, o_lcd_B
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an RGB565 LCD: pixel coordinates for the renderer and
// panel HS/VS/DE delayed to line up with the renderer's registered colour.
module lcd_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 13,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 29,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int PIX_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  lcd_timing_gen_if.master  lcd
);

  // Region boundaries are summed as ints and then sized, so nothing wraps.
  localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_ACT_W    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [10:0] h_cnt_reg, h_cnt_next;
  logic [9:0]  v_cnt_reg, v_cnt_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  always_comb begin
    h_cnt_next = h_cnt_reg + 11'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
    end
  end

  logic active, h_in_sync, v_in_sync;
  logic hs_raw, vs_raw, de_raw;

  assign active    = (h_cnt_reg < H_ACT_W) && (v_cnt_reg < V_ACT_W);
  assign h_in_sync = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
  assign v_in_sync = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
  assign hs_raw    = h_in_sync ? HS_POL : ~HS_POL;
  assign vs_raw    = v_in_sync ? VS_POL : ~VS_POL;
  // Counters sit at (0,0) in reset, which is "active"; keep DE low until release.
  assign de_raw    = active & i_rst_n;

  assign lcd.o_x           = active ? h_cnt_reg[9:0] : 10'd0;
  assign lcd.o_y           = active ? v_cnt_reg : 10'd0;
  assign lcd.o_frame_start = i_rst_n && (h_cnt_reg == 11'd0) && (v_cnt_reg == 10'd0);

  logic hs_out, vs_out, de_out;

  genvar gi;
  generate
    for (gi = 0; gi < PIX_LATENCY; gi++) begin : g_stage
      logic hs_d, vs_d, de_d;
      logic hs_q_reg, vs_q_reg, de_q_reg;

      if (gi == 0) begin : g_first
        assign hs_d = hs_raw;
        assign vs_d = vs_raw;
        assign de_d = de_raw;
      end else begin : g_next
        assign hs_d = g_stage[gi-1].hs_q_reg;
        assign vs_d = g_stage[gi-1].vs_q_reg;
        assign de_d = g_stage[gi-1].de_q_reg;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          hs_q_reg <= ~HS_POL;
          vs_q_reg <= ~VS_POL;
          de_q_reg <= 1'b0;
        end else begin
          hs_q_reg <= hs_d;
          vs_q_reg <= vs_d;
          de_q_reg <= de_d;
        end
      end
    end

    if (PIX_LATENCY == 0) begin : g_no_delay
      assign hs_out = hs_raw;
      assign vs_out = vs_raw;
      assign de_out = de_raw;
    end else begin : g_delay_out
      assign hs_out = g_stage[PIX_LATENCY-1].hs_q_reg;
      assign vs_out = g_stage[PIX_LATENCY-1].vs_q_reg;
      assign de_out = g_stage[PIX_LATENCY-1].de_q_reg;
    end
  endgenerate

  assign lcd.o_lcd_hs = hs_out;
  assign lcd.o_lcd_vs = vs_out;
  assign lcd.o_lcd_de = de_out;

  // Colour arrives already aligned by the renderer; only the blanking gate lives here.
  assign lcd.o_lcd_R = de_out ? lcd.i_R : 5'd0;
  assign lcd.o_lcd_G = de_out ? lcd.i_G : 6'd0;
  assign lcd.o_lcd_B = de_out ? lcd.i_B : 5'd0;

endmodule
